cp0_tlb_timer_unit: RTL
=======================

// Module: cp0_tlb_timer_unit
// PURPOSE
//  Parametrised CP0 successor for the MIPS core: system-control register file with configurable TLB depth,
//  HW-IRQ count and count prescaler. Adds TLBP/TLBR result loading, nested-exception EPC protection,
//  working Wired/Random, TLB-refill EntryHi/Context update, and computed interrupt request and vector.
//  Sits beside the MEM/WB stage; the TLB array and exception arbiter live outside this block.
// PARAMETERS
//  TLB_LINES   16            number of TLB entries (power of 2, 2..64)
//  IDX_W       $clog2(TLB_LINES)  index width
//  COUNT_DIV   2             Count increments once every COUNT_DIV cycles (power of 2, >=1)
//  NUM_HW_IRQ  5             external HW irq lines mapped to Cause.IP2.. (max 5; IP7 = timer)
//  RESET_EBASE 32'h8000_0000 reset value of EBase
// PORTS
//  clk             in  1   clock
//  rst_n           in  1   synchronous reset, active-low
//  we_i            in  1   MTC0 write strobe
//  waddr_i/wsel_i  in  5/3 MTC0 register/select
//  wdata_i         in  32  MTC0 data
//  raddr_i/rsel_i  in  5/3 MFC0 register/select
//  rdata_o         out 32  MFC0 data, combinational from current regs; 0 for unimplemented
//  int_i           in  NUM_HW_IRQ  level-sensitive HW interrupts
//  exc_valid_i     in  1   exception commit this cycle
//  exc_code_i      in  5   ExcCode of committed exception
//  exc_pc_i        in  32  PC of faulting instruction
//  exc_bd_i        in  1   faulting instruction in delay slot
//  exc_badva_i     in  32  faulting address
//  eret_i          in  1   ERET commit
//  tlbp_i          in  1   TLBP result valid
//  tlbp_hit_i      in  1   probe hit
//  tlbp_idx_i      in  IDX_W  hit index
//  tlbr_i          in  1   TLBR data valid
//  tlbr_hi_i/tlbr_pm_i/tlbr_lo0_i/tlbr_lo1_i  in 32 each  entry read by TLBR
//  status_o/cause_o/epc_o  out 32  architectural regs
//  entryhi_o/pagemask_o/entrylo0_o/entrylo1_o  out 32  TLB write data
//  tlbwi_idx_o     out IDX_W  Index[IDX_W-1:0]
//  tlbwr_idx_o     out IDX_W  Random
//  irq_o           out 1   interrupt pending and enabled (combinational)
//  exc_vector_o    out 32  redirect target (combinational)
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): Status=0x0040_0004 (BEV=1,ERL=1); Random=TLB_LINES-1; EBase=RESET_EBASE;
//   Config0=0x0000_8003; others, prescaler, timer-pending, all outputs derived = 0. Reset wins over all.
//  Write masks: Status CU0[28],BEV[22],IM[15:8],UM[4],ERL[2],EXL[1],IE[0]; Cause IV[23],IP[9:8];
//   EntryHi {[31:13],[7:0]}; EntryLo0/1 [29:0]; PageMask [28:13]; Index [IDX_W-1:0] (P kept);
//   Wired [IDX_W-1:0]; Context PTEBase[31:23]; EBase [29:12] sel 1; Config0 K0[2:0]; PRId/BadVAddr read-only.
//  Same-cycle priority per field: exception/ERET > TLBP/TLBR > MTC0 > free-running update.
//  Count: prescaler wraps every COUNT_DIV cycles, Count+1 on wrap (mod 2^32). MTC0 Count loads value and clears prescaler.
//  Timer: when Count increments to value == Compare, set TI (Cause[30]); IP7=TI. MTC0 Compare clears TI.
//  Cause.IP[6:2] = int_i sampled each cycle (1-cycle latency); unused lines read 0.
//  Random: each cycle Random = (Random==Wired) ? TLB_LINES-1 : Random-1. MTC0 Wired sets Random=TLB_LINES-1.
//   If Wired >= TLB_LINES-1, Random holds TLB_LINES-1.
//  TLBP: Index[31]=~hit; on hit Index[IDX_W-1:0]=tlbp_idx_i, on miss low bits unchanged.
//  TLBR: EntryHi/PageMask/EntryLo0/EntryLo1 loaded with masked tlbr_* inputs next edge.
//  Exception (exc_valid_i): ExcCode=exc_code_i; if EXL==0: EPC=exc_bd_i?exc_pc_i-4:exc_pc_i, BD=exc_bd_i;
//   if EXL==1 EPC and BD unchanged (nested). EXL=1.
//   Codes 1,2,3,4,5 (Mod,TLBL,TLBS,AdEL,AdES) load BadVAddr; codes 1,2,3 also load EntryHi[31:13] and Context[22:4]=badva[31:13].
//  ERET: ERL?ERL=0:EXL=0. exc_valid_i with eret_i -> exception wins, ERET ignored.
//  irq_o = IE & ~EXL & ~ERL & |(IP[7:0] & IM[7:0]).
//  exc_vector_o: eret_i -> ERL?0:EPC; else base=BEV?0xBFC0_0200:EBase; offset 0x000 if EXL==0 and code in {2,3}
//   (refill), else 0x180.
// TESTING
//  Reset: rst_n low 1 cycle -> Status=0x0040_0004, Random=15, EBase=0x8000_0000, irq_o=0.
//  Timer: COUNT_DIV=2, Compare=10, IM7=1, IE=1, EXL=ERL=0 -> TI set edge Count becomes 10 (~cycle 20), irq_o=1; write Compare -> TI=0.
//  Nested exc: code 4, pc 0x8000_0104, bd=1 -> EPC=0x8000_0100, BD=1, BadVAddr=badva; second exc while EXL=1 -> EPC unchanged.
//  Random/Wired: Wired=12 -> Random 15,14,13,12,15...; Wired=15 -> Random stuck 15.
//  TLBP miss then hit idx 7 -> Index=0x8000_0000|old low, then 0x0000_0007; TLBR same cycle as MTC0 EntryHi -> TLBR value kept.
//  Simultaneous exc_valid_i+eret_i; reset mid-timer -> exception taken/EXL=1; all regs reset values next edge.

Source files
------------

// File: rtl/cp0_tlb_timer_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_tlb_timer_unit_if
//  Description : MTC0 write / MFC0 read bus between the pipeline and CP0.
//                we_i, waddr_i, wsel_i, wdata_i : MTC0 strobe, register, select, data
//                raddr_i, rsel_i                : MFC0 register, select
//                rdata_o                        : MFC0 data (combinational)
//                master = pipeline side, slave = CP0 side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cp0_tlb_timer_unit_if;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [2:0]  wsel_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [2:0]  rsel_i;
    logic [31:0] rdata_o;

    modport master (output we_i, waddr_i, wsel_i, wdata_i, raddr_i, rsel_i,
                    input  rdata_o);
    modport slave  (input  we_i, waddr_i, wsel_i, wdata_i, raddr_i, rsel_i,
                    output rdata_o);
endinterface
`default_nettype wire

// File: rtl/cp0_tlb_timer_unit.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_tlb_timer_unit
//  Description : CP0 system-control register file: Count/Compare timer with
//                prescaler, Wired/Random, TLBP/TLBR result loading, exception
//                and ERET state update with nested-EPC protection, interrupt
//                request and redirect vector.
//  Ports       : clk, rst_n (sync, active-low); bus (MTC0/MFC0, slave);
//                int_i (HW irqs); exc_* / eret_i (commit events);
//                tlbp_* / tlbr_* (TLB results); status_o, cause_o, epc_o,
//                entryhi_o, pagemask_o, entrylo0_o, entrylo1_o,
//                tlbwi_idx_o, tlbwr_idx_o, irq_o, exc_vector_o.
//  Revision    : 1.0 - initial release
// ============================================================================
module cp0_tlb_timer_unit #(
    parameter int unsigned TLB_LINES   = 16,
    parameter int unsigned IDX_W       = $clog2(TLB_LINES),
    parameter int unsigned COUNT_DIV   = 2,
    parameter int unsigned NUM_HW_IRQ  = 5,
    parameter logic [31:0] RESET_EBASE = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cp0_tlb_timer_unit_if.slave   bus,
    input  logic [NUM_HW_IRQ-1:0] int_i,
    input  logic                  exc_valid_i,
    input  logic [4:0]            exc_code_i,
    input  logic [31:0]           exc_pc_i,
    input  logic                  exc_bd_i,
    input  logic [31:0]           exc_badva_i,
    input  logic                  eret_i,
    input  logic                  tlbp_i,
    input  logic                  tlbp_hit_i,
    input  logic [IDX_W-1:0]      tlbp_idx_i,
    input  logic                  tlbr_i,
    input  logic [31:0]           tlbr_hi_i,
    input  logic [31:0]           tlbr_pm_i,
    input  logic [31:0]           tlbr_lo0_i,
    input  logic [31:0]           tlbr_lo1_i,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o,
    output logic [31:0]           entryhi_o,
    output logic [31:0]           pagemask_o,
    output logic [31:0]           entrylo0_o,
    output logic [31:0]           entrylo1_o,
    output logic [IDX_W-1:0]      tlbwi_idx_o,
    output logic [IDX_W-1:0]      tlbwr_idx_o,
    output logic                  irq_o,
    output logic [31:0]           exc_vector_o
);
    localparam int unsigned PW          = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0]    C_PRESC_MAX = PW'(COUNT_DIV - 1);
    localparam logic [IDX_W-1:0] C_RAND_MAX  = IDX_W'(TLB_LINES - 1);
    localparam logic [31:0] C_STATUS_RST = 32'h0040_0004;
    localparam logic [31:0] C_STATUS_WM  = 32'h1040_FF17;
    localparam logic [31:0] C_EHI_WM     = 32'hFFFF_E0FF;
    localparam logic [31:0] C_LO_WM      = 32'h3FFF_FFFF;
    localparam logic [31:0] C_PM_WM      = 32'h1FFF_E000;
    localparam logic [31:0] C_CTX_WM     = 32'hFF80_0000;
    localparam logic [31:0] C_EBASE_WM   = 32'h3FFF_F000;

    logic [31:0]      status_q, status_d, epc_q, epc_d, badva_q, badva_d;
    logic [31:0]      count_q, count_d, compare_q, compare_d, context_q, context_d;
    logic [31:0]      entryhi_q, entryhi_d, pagemask_q, pagemask_d;
    logic [31:0]      lo0_q, lo0_d, lo1_q, lo1_d, ebase_q, ebase_d;
    logic             bd_q, bd_d, ti_q, ti_d, iv_q, iv_d, index_p_q, index_p_d;
    logic [1:0]       ip_sw_q, ip_sw_d;
    logic [4:0]       ip_hw_q, ip_hw_d, exccode_q, exccode_d;
    logic [2:0]       k0_q, k0_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [IDX_W-1:0] index_q, index_d, wired_q, wired_d, random_q, random_d;

    // Unused HW interrupt lines read as zero in Cause.IP.
    logic [4:0] w_int_ext;
    generate
        if (NUM_HW_IRQ >= 5) begin : g_irq_full
            assign w_int_ext = int_i[4:0];
        end else begin : g_irq_pad
            assign w_int_ext = {{(5 - NUM_HW_IRQ){1'b0}}, int_i};
        end
    endgenerate

    logic [7:0]  w_wa;
    logic        w_wrap;
    logic [31:0] w_count_inc, w_cause, w_base;
    logic        w_refill;
    assign w_wa        = {bus.waddr_i, bus.wsel_i};
    assign w_wrap      = (presc_q == C_PRESC_MAX);
    assign w_count_inc = count_q + 32'd1;
    assign w_cause     = {bd_q, ti_q, 6'd0, iv_q, 7'd0, ti_q, ip_hw_q, ip_sw_q,
                          1'b0, exccode_q, 2'b00};

    // Priority per field is expressed by assignment order: free-running
    // update first, then MTC0, then TLBP/TLBR, then exception/ERET last.
    always_comb begin
        status_d = status_q;   bd_d = bd_q;           ti_d = ti_q;
        iv_d = iv_q;           ip_sw_d = ip_sw_q;     exccode_d = exccode_q;
        epc_d = epc_q;         badva_d = badva_q;     compare_d = compare_q;
        entryhi_d = entryhi_q; pagemask_d = pagemask_q;
        lo0_d = lo0_q;         lo1_d = lo1_q;         context_d = context_q;
        index_p_d = index_p_q; index_d = index_q;     wired_d = wired_q;
        ebase_d = ebase_q;     k0_d = k0_q;
        ip_hw_d  = w_int_ext;
        presc_d  = w_wrap ? '0 : presc_q + 1'b1;
        count_d  = w_wrap ? w_count_inc : count_q;
        if (w_wrap && (w_count_inc == compare_q)) ti_d = 1'b1;
        random_d = ((wired_q >= C_RAND_MAX) || (random_q == wired_q)) ? C_RAND_MAX
                                                                     : random_q - 1'b1;
        if (bus.we_i) begin
            case (w_wa)
                {5'd0, 3'd0}:  index_d = bus.wdata_i[IDX_W-1:0];
                {5'd2, 3'd0}:  lo0_d = bus.wdata_i & C_LO_WM;
                {5'd3, 3'd0}:  lo1_d = bus.wdata_i & C_LO_WM;
                {5'd4, 3'd0}:  context_d = (context_q & ~C_CTX_WM) | (bus.wdata_i & C_CTX_WM);
                {5'd5, 3'd0}:  pagemask_d = bus.wdata_i & C_PM_WM;
                {5'd6, 3'd0}:  begin wired_d = bus.wdata_i[IDX_W-1:0]; random_d = C_RAND_MAX; end
                {5'd9, 3'd0}:  begin count_d = bus.wdata_i; presc_d = '0; end
                {5'd10, 3'd0}: entryhi_d = bus.wdata_i & C_EHI_WM;
                {5'd11, 3'd0}: begin compare_d = bus.wdata_i; ti_d = 1'b0; end
                {5'd12, 3'd0}: status_d = (status_q & ~C_STATUS_WM) | (bus.wdata_i & C_STATUS_WM);
                {5'd13, 3'd0}: begin iv_d = bus.wdata_i[23]; ip_sw_d = bus.wdata_i[9:8]; end
                {5'd14, 3'd0}: epc_d = bus.wdata_i;
                {5'd15, 3'd1}: ebase_d = (ebase_q & ~C_EBASE_WM) | (bus.wdata_i & C_EBASE_WM);
                {5'd16, 3'd0}: k0_d = bus.wdata_i[2:0];
                default: ;
            endcase
        end
        if (tlbp_i) begin
            index_p_d = ~tlbp_hit_i;
            if (tlbp_hit_i) index_d = tlbp_idx_i;
        end
        if (tlbr_i) begin
            entryhi_d  = tlbr_hi_i & C_EHI_WM;
            pagemask_d = tlbr_pm_i & C_PM_WM;
            lo0_d      = tlbr_lo0_i & C_LO_WM;
            lo1_d      = tlbr_lo1_i & C_LO_WM;
        end
        if (exc_valid_i) begin
            exccode_d = exc_code_i;
            // A nested exception (EXL already set) must not lose the original EPC.
            if (!status_q[1]) begin
                epc_d = exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i;
                bd_d  = exc_bd_i;
            end
            status_d[1] = 1'b1;
            if ((exc_code_i >= 5'd1) && (exc_code_i <= 5'd5)) badva_d = exc_badva_i;
            if ((exc_code_i >= 5'd1) && (exc_code_i <= 5'd3)) begin
                entryhi_d[31:13] = exc_badva_i[31:13];
                context_d[22:4]  = exc_badva_i[31:13];
            end
        end else if (eret_i) begin
            if (status_q[2]) status_d[2] = 1'b0;
            else             status_d[1] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            status_q <= C_STATUS_RST; bd_q <= 1'b0;   ti_q <= 1'b0;   iv_q <= 1'b0;
            ip_sw_q <= '0;   ip_hw_q <= '0;   exccode_q <= '0; epc_q <= '0;
            badva_q <= '0;   count_q <= '0;   compare_q <= '0; presc_q <= '0;
            entryhi_q <= '0; pagemask_q <= '0; lo0_q <= '0;   lo1_q <= '0;
            context_q <= '0; index_p_q <= 1'b0; index_q <= '0; wired_q <= '0;
            random_q <= C_RAND_MAX; ebase_q <= RESET_EBASE;   k0_q <= 3'd3;
        end else begin
            status_q <= status_d; bd_q <= bd_d;   ti_q <= ti_d;   iv_q <= iv_d;
            ip_sw_q <= ip_sw_d;   ip_hw_q <= ip_hw_d; exccode_q <= exccode_d; epc_q <= epc_d;
            badva_q <= badva_d;   count_q <= count_d; compare_q <= compare_d; presc_q <= presc_d;
            entryhi_q <= entryhi_d; pagemask_q <= pagemask_d; lo0_q <= lo0_d; lo1_q <= lo1_d;
            context_q <= context_d; index_p_q <= index_p_d; index_q <= index_d; wired_q <= wired_d;
            random_q <= random_d; ebase_q <= ebase_d; k0_q <= k0_d;
        end
    end

    always_comb begin
        bus.rdata_o = 32'd0;
        case ({bus.raddr_i, bus.rsel_i})
            {5'd0, 3'd0}:  bus.rdata_o = {index_p_q, {(31 - IDX_W){1'b0}}, index_q};
            {5'd1, 3'd0}:  bus.rdata_o = {{(32 - IDX_W){1'b0}}, random_q};
            {5'd2, 3'd0}:  bus.rdata_o = lo0_q;
            {5'd3, 3'd0}:  bus.rdata_o = lo1_q;
            {5'd4, 3'd0}:  bus.rdata_o = context_q;
            {5'd5, 3'd0}:  bus.rdata_o = pagemask_q;
            {5'd6, 3'd0}:  bus.rdata_o = {{(32 - IDX_W){1'b0}}, wired_q};
            {5'd8, 3'd0}:  bus.rdata_o = badva_q;
            {5'd9, 3'd0}:  bus.rdata_o = count_q;
            {5'd10, 3'd0}: bus.rdata_o = entryhi_q;
            {5'd11, 3'd0}: bus.rdata_o = compare_q;
            {5'd12, 3'd0}: bus.rdata_o = status_q;
            {5'd13, 3'd0}: bus.rdata_o = w_cause;
            {5'd14, 3'd0}: bus.rdata_o = epc_q;
            {5'd15, 3'd1}: bus.rdata_o = ebase_q & 32'hFFFF_F000;
            {5'd16, 3'd0}: bus.rdata_o = 32'h0000_8000 | {29'd0, k0_q};
            default:       bus.rdata_o = 32'd0;
        endcase
    end

    // A refill (TLBL/TLBS taken with EXL clear) uses offset 0; all else 0x180.
    // When an exception and ERET commit together the exception wins, so the
    // vector follows the exception too.
    assign w_refill = !status_q[1] && ((exc_code_i == 5'd2) || (exc_code_i == 5'd3));
    assign w_base   = status_q[22] ? 32'hBFC0_0200 : (ebase_q & 32'hFFFF_F000);
    always_comb begin
        if (eret_i && !exc_valid_i) exc_vector_o = status_q[2] ? 32'd0 : epc_q;
        else                        exc_vector_o = w_base + (w_refill ? 32'd0 : 32'h180);
    end

    assign status_o    = status_q;
    assign cause_o     = w_cause;
    assign epc_o       = epc_q;
    assign entryhi_o   = entryhi_q;
    assign pagemask_o  = pagemask_q;
    assign entrylo0_o  = lo0_q;
    assign entrylo1_o  = lo1_q;
    assign tlbwi_idx_o = index_q;
    assign tlbwr_idx_o = random_q;
    assign irq_o       = status_q[0] & ~status_q[1] & ~status_q[2] &
                         (|(w_cause[15:8] & status_q[15:8]));
endmodule
`default_nettype wire
